apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator that turns a simple valid/ready CPU-side request into APB SETUP/ACCESS transfers toward up to NUM_SLAVES peripherals (FND, GPIO, UART, ...).
- Decodes the slave from the address, drives a one-hot PSEL, and muxes PRDATA/PREADY back.
- Returns a single-cycle response. One outstanding transfer at a time.

Parameters:
- NUM_SLAVES, 4, number of APB slaves (1..16).
- BASE_ADDR, 32'h1000_0000, peripheral window base; bits [31:16] must match.
- TIMEOUT_CYCLES, 255, max ACCESS cycles without PREADY (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock; single clock domain.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data (0 for writes/errors).
- rsp_err  out  1  decode error or timeout.
- PADDR  out  32  APB address (latched req_addr).
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA_bus  in  NUM_SLAVES*32  slave i read data at [32*i+31:32*i].
- PREADY_bus  in  NUM_SLAVES  slave i ready.

Behaviour:
- Reset is synchronous to PCLK and active-high. It forces state IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the latched slave index all go to 0.
- req_ready = (state==IDLE) & ~PRESET.
- Decode: idx = req_addr[15:12]. Hit when req_addr[31:16]==BASE_ADDR[31:16] and idx < NUM_SLAVES.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - On req_valid&req_ready with a hit: latch addr/wdata/write/idx, then go to SETUP.
  - On a miss: stay in IDLE, drive no PSEL, and the next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0.
- SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWDATA/PWRITE stable. Always goes to ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1, all address/data/control held stable.
  - Sampled PREADY_bus[idx]=1 → capture PRDATA_bus[idx] (reads) or 0 (writes) into rsp_rdata, set rsp_err=0, go to IDLE.
  - The following cycle gives rsp_valid=1 and drops PSEL/PENABLE.
  - PREADY=0 → stay in ACCESS (wait state). There is no limit unless the optional feature is enabled.
- Response timing: rsp_valid is a one-cycle registered pulse. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are held until the next response.
- Latency with a zero-wait slave, accept at edge 0: SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
- Latency with the FND-style slave (PREADY registered one cycle after PSEL&PENABLE): rsp_valid in cycle 4.
- req_ready is high in the same cycle as rsp_valid, so back-to-back requests are accepted with no bubble beyond the response cycle.
- PREADY/PRDATA of non-selected slaves, and of any slave outside ACCESS, are ignored. This covers a stale registered PREADY still high in the cycle after ACCESS.
- PADDR/PWDATA/PWRITE keep their last values in IDLE. Only PSEL/PENABLE return to 0.
- Reset mid-transfer (SETUP or ACCESS): the next cycle is IDLE with PSEL=0 and PENABLE=0. No rsp_valid is issued for the aborted transfer.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, abort: go to IDLE and drop PSEL/PENABLE.
  - Next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Test Plan:
1. Write 32'h0000_1234 to 32'h1000_1000 (slave 1, PREADY one cycle after ACCESS):
   - PSEL=4'b0010 with PENABLE=0 for one cycle, then PENABLE=1 for 2 cycles.
   - PWDATA=32'h1234 throughout; rsp_valid at cycle 4 with rsp_err=0, rsp_rdata=0.
2. Read 32'h1000_0004 from slave 0 returning PRDATA=32'h0000_0001 with 3 wait states:
   - rsp_rdata=1 and rsp_valid at cycle 6.
   - PADDR/PSEL stable through all ACCESS cycles.
3. Decode errors:
   - Request to 32'h1000_5000 (idx 5 ≥ 4) → no PSEL ever asserted; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
   - Same result for 32'h2000_0000.
4. Back-to-back write then read, with req_valid held:
   - Second request accepted in the rsp_valid cycle of the first.
   - Slave 1's stale PREADY=1 in that cycle does not complete the second transfer.
5. Reset mid-transfer: PRESET=1 for 1 cycle during ACCESS → next cycle PSEL=0, PENABLE=0, state IDLE, no rsp_valid; req_ready=1 after PRESET falls.
6. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY held 0:
   - Abort after 8 ACCESS cycles; rsp_err=1, rsp_rdata=0.
   - Without the macro, same stimulus gives no rsp_valid for 1000 cycles.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator bridging a valid/ready request port to NUM_SLAVES APB peripherals.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [NUM_SLAVES*32-1:0] PRDATA_bus,
    input  logic [NUM_SLAVES-1:0]    PREADY_bus
);

    localparam int unsigned IdxW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [4:0]  NumSlv = 5'(NUM_SLAVES);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                state_q;
    logic [IdxW-1:0]       idx_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [31:0]           paddr_q;
    logic [31:0]           pwdata_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic                  hit;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (req_addr[15:12] == 4'(i)) dec_sel[i] = 1'b1;
        end
        hit = (req_addr[31:16] == BASE_ADDR[31:16]) && ({1'b0, req_addr[15:12]} < NumSlv);
        // Only the latched slave's handshake is ever looked at.
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_ready = PREADY_bus[i];
                sel_rdata = PRDATA_bus[32*i +: 32];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    if (req_valid) begin
                        if (hit) begin
                            paddr_q  <= req_addr;
                            pwdata_q <= req_wdata;
                            pwrite_q <= req_write;
                            idx_q    <= IdxW'(req_addr[15:12]);
                            psel_q   <= dec_sel;
                            state_q  <= StSetup;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                StAccess: begin
                    if (sel_ready) begin
                        rsp_rdata_q <= pwrite_q ? 32'h0 : sel_rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= StIdle;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt_q == TimeoutLast) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle) & ~PRESET;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;
    assign PSEL      = psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: slave 0 has 3 wait states, slave 1 registers PREADY,
// slave 2 never answers, slave 3 is zero-wait.
module tb_apb_master_bridge;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic         rsp_valid, rsp_err;
    logic [31:0]  rsp_rdata;
    logic [31:0]  PADDR, PWDATA;
    logic         PWRITE, PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA_bus;
    logic [3:0]   PREADY_bus;

    int n_cmp = 0;
    int n_err = 0;

    logic       pready1_q;
    logic [3:0] wcnt0_q;
    logic       pready0;

    apb_master_bridge #(
        .NUM_SLAVES    (4),
        .BASE_ADDR     (32'h1000_0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA_bus(PRDATA_bus),
        .PREADY_bus(PREADY_bus)
    );

    initial forever #5 PCLK = ~PCLK;

    // Slave models
    assign pready0 = PSEL[0] & PENABLE & (wcnt0_q == 4'd3);
    always @(posedge PCLK) begin
        if (PRESET) begin
            pready1_q <= 1'b0;
            wcnt0_q   <= '0;
        end else begin
            pready1_q <= PSEL[1] & PENABLE;
            wcnt0_q   <= (PSEL[0] & PENABLE & ~pready0) ? wcnt0_q + 4'd1 : 4'd0;
        end
    end
    assign PREADY_bus = {PSEL[3] & PENABLE, 1'b0, pready1_q, pready0};
    assign PRDATA_bus = {32'h3333_3333, 32'h2222_2222, 32'hAAAA_0001, 32'h0000_0001};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Presents a request for one edge; caller is in a cycle with req_ready=1.
    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        PRESET    = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h1000_1000;
        req_wdata = 32'hDEAD_BEEF;
        tick();
        tick();
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        n_cmp++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {PADDR, PWDATA, rsp_rdata});
        end
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low: got %b want 0", req_ready);
        end
        req_valid = 1'b0;
        PRESET    = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_high: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_fnd;
        start_req(1'b1, 32'h1000_1000, 32'h0000_1234);
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, req_ready} !== 7'b0010_0_1_0) begin
            n_err++;
            $display("FAIL wr_setup: got %b want 0010010", {PSEL, PENABLE, PWRITE, req_ready});
        end
        n_cmp++;
        if ({PADDR, PWDATA} !== {32'h1000_1000, 32'h0000_1234}) begin
            n_err++; $display("FAIL wr_setup_addr_data: got %h want 1000100000001234", {PADDR, PWDATA});
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            n_cmp++;
            if ({PSEL, PENABLE, rsp_valid, PWDATA} !== {4'b0010, 1'b1, 1'b0, 32'h1234}) begin
                n_err++;
                $display("FAIL wr_access_c%0d: got %h want %h", c, {PSEL, PENABLE, rsp_valid, PWDATA},
                         {4'b0010, 1'b1, 1'b0, 32'h1234});
            end
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL wr_rsp: got %h want 200000000", {rsp_valid, rsp_err, rsp_rdata});
        end
        n_cmp++;
        if ({PSEL, PENABLE, req_ready, PWDATA} !== {4'b0000, 1'b0, 1'b1, 32'h1234}) begin
            n_err++; $display("FAIL wr_rsp_bus: got %h want %h", {PSEL, PENABLE, req_ready, PWDATA},
                              {4'b0000, 1'b0, 1'b1, 32'h1234});
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait;
        start_req(1'b0, 32'h1000_0004, 32'h0);
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE} !== 6'b0001_0_0) begin
            n_err++; $display("FAIL rd_setup: got %b want 000100", {PSEL, PENABLE, PWRITE});
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_cmp++;
            if ({PSEL, PENABLE, rsp_valid, PADDR} !== {4'b0001, 1'b1, 1'b0, 32'h1000_0004}) begin
                n_err++;
                $display("FAIL rd_access_c%0d: got %h want %h", c, {PSEL, PENABLE, rsp_valid, PADDR},
                         {4'b0001, 1'b1, 1'b0, 32'h1000_0004});
            end
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1}) begin
            n_err++; $display("FAIL rd_rsp: got %h want 200000001", {rsp_valid, rsp_err, rsp_rdata});
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_rdata, PADDR} !== {1'b0, 32'h1, 32'h1000_0004}) begin
            n_err++; $display("FAIL rd_hold: got %h want %h", {rsp_valid, rsp_rdata, PADDR},
                              {1'b0, 32'h1, 32'h1000_0004});
        end
    endtask

    task automatic test_decode_err;
        logic [31:0] bad [2];
        bad[0] = 32'h1000_5000;
        bad[1] = 32'h2000_0000;
        for (int k = 0; k < 2; k++) begin
            start_req(k[0], bad[k], 32'hFFFF_FFFF);
            n_cmp++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
                n_err++; $display("FAIL dec_rsp_%0d: got %h want 300000000", k,
                                  {rsp_valid, rsp_err, rsp_rdata});
            end
            n_cmp++;
            if ({PSEL, PENABLE, req_ready} !== 6'b0000_0_1) begin
                n_err++; $display("FAIL dec_bus_%0d: got %b want 000001", k, {PSEL, PENABLE, req_ready});
            end
            tick();
            n_cmp++;
            if ({PSEL, rsp_valid} !== 5'b0) begin
                n_err++; $display("FAIL dec_after_%0d: got %b want 00000", k, {PSEL, rsp_valid});
            end
        end
    endtask

    task automatic test_zero_wait;
        start_req(1'b0, 32'h1000_3010, 32'h0);
        tick();
        n_cmp++;
        if ({PSEL, PENABLE, rsp_valid} !== 6'b1000_1_0) begin
            n_err++; $display("FAIL zw_access: got %b want 100010", {PSEL, PENABLE, rsp_valid});
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h3333_3333}) begin
            n_err++; $display("FAIL zw_rsp: got %h want 233333333", {rsp_valid, rsp_err, rsp_rdata});
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h1000_1000;
        req_wdata = 32'h0000_5555;
        tick();
        req_write = 1'b0;
        req_addr  = 32'h1000_1008;
        req_wdata = 32'h0;
        n_cmp++;
        if ({req_ready, PWRITE} !== 2'b01) begin
            n_err++; $display("FAIL b2b_busy: got %b want 01", {req_ready, PWRITE});
        end
        tick();
        tick();
        n_cmp++;
        if ({PADDR, PWDATA} !== {32'h1000_1000, 32'h5555}) begin
            n_err++; $display("FAIL b2b_first_stable: got %h want 1000100000005555", {PADDR, PWDATA});
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, req_ready} !== 3'b101) begin
            n_err++; $display("FAIL b2b_first_rsp: got %b want 101", {rsp_valid, rsp_err, req_ready});
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, PADDR} !== {4'b0010, 3'b000, 32'h1000_1008}) begin
            n_err++; $display("FAIL b2b_second_setup: got %h want %h",
                              {PSEL, PENABLE, PWRITE, rsp_valid, PADDR}, {4'b0010, 3'b000, 32'h1000_1008});
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid !== 1'b1 && n < 20);
        n_cmp++;
        if (n != 3) begin
            n_err++; $display("FAIL b2b_second_latency: got %0d cycles want 3", n);
        end
        n_cmp++;
        if ({rsp_err, rsp_rdata} !== {1'b0, 32'hAAAA_0001}) begin
            n_err++; $display("FAIL b2b_second_rdata: got %h want 0aaaa0001", {rsp_err, rsp_rdata});
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int seen;
        start_req(1'b0, 32'h1000_2000, 32'h0);
        tick();
        n_cmp++;
        if ({PSEL, PENABLE} !== 5'b0100_1) begin
            n_err++; $display("FAIL rst_mid_access: got %b want 01001", {PSEL, PENABLE});
        end
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        #1;
        n_cmp++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 7'b0000_0_0_1) begin
            n_err++; $display("FAIL rst_mid_after: got %b want 0000001",
                              {PSEL, PENABLE, rsp_valid, req_ready});
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rsp_valid === 1'b1 || PSEL !== 4'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL rst_mid_no_rsp: got %0d cycles with activity want 0", seen);
        end
    endtask

    task automatic test_timeout;
        start_req(1'b1, 32'h1000_2004, 32'h0000_0077);
`ifdef APB_TIMEOUT_EN
        for (int c = 2; c <= 9; c++) begin
            tick();
            n_cmp++;
            if ({PSEL, PENABLE, rsp_valid} !== 6'b0100_1_0) begin
                n_err++; $display("FAIL tmo_wait_c%0d: got %b want 010010", c, {PSEL, PENABLE, rsp_valid});
            end
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL tmo_rsp: got %h want 300000000", {rsp_valid, rsp_err, rsp_rdata});
        end
        n_cmp++;
        if ({PSEL, PENABLE, req_ready} !== 6'b0000_0_1) begin
            n_err++; $display("FAIL tmo_bus: got %b want 000001", {PSEL, PENABLE, req_ready});
        end
        tick();
`else
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (rsp_valid === 1'b1) seen++;
            end
            n_cmp++;
            if (seen != 0) begin
                n_err++; $display("FAIL notmo_rsp: got %0d responses want 0", seen);
            end
            n_cmp++;
            if ({PSEL, PENABLE, req_ready} !== 6'b0100_1_0) begin
                n_err++; $display("FAIL notmo_bus: got %b want 010010", {PSEL, PENABLE, req_ready});
            end
            PRESET = 1'b1;
            tick();
            PRESET = 1'b0;
            tick();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_fnd();
        test_read_wait();
        test_decode_err();
        test_zero_wait();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
